// File: rtl/dec_scan_nto2n_if.sv
// Select/strobe bundle for dec_scan_nto2n: control side drives en/mode/i,
// decoder side returns the registered one-hot q, its index and the scan wrap pulse.
interface dec_scan_nto2n_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_N = 2**SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] i;
    logic [OUT_N-1:0] q;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (output en, mode, i, input q, idx, wrap);
    modport slave  (input en, mode, i, output q, idx, wrap);
endinterface

// File: rtl/dec_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct and autonomous scan modes.
// Optional feature: define DEC_BLANK_EN to insert one blank cycle at each scan advance.
module dec_scan_nto2n #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dec_scan_nto2n_if.slave bus
);
    localparam int                OUT_N    = 2**SEL_W;
    localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [OUT_N-1:0]  HOT_0    = {{(OUT_N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
`ifdef DEC_BLANK_EN
        , ST_BLANK = 2'd3
`endif
    } state_t;

    function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] sel);
        return HOT_0 << sel;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [OUT_N-1:0] q_r, q_nxt_s;
    logic [SEL_W-1:0] idx_r, idx_nxt_s, idx_inc_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             wrap_r, wrap_nxt_s;
    logic             advance_s;

    // Next state from en/mode plus next values of every registered output.
    always_comb begin
        state_nxt_s = ST_IDLE;
        q_nxt_s     = '0;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = '0;
        wrap_nxt_s  = 1'b0;
        idx_inc_s   = idx_r + SEL_W'(1);
        advance_s   = (state_r == ST_SCAN) && (cnt_r == CNT_LAST);

        if (!bus.en) begin
            state_nxt_s = ST_IDLE;
        end else if (!bus.mode) begin
            state_nxt_s = ST_DIRECT;
        end else if (advance_s) begin
`ifdef DEC_BLANK_EN
            state_nxt_s = ST_BLANK;
`else
            state_nxt_s = ST_SCAN;
`endif
        end else begin
            state_nxt_s = ST_SCAN;
        end

        case (state_nxt_s)
            ST_IDLE: begin
                q_nxt_s = '0;
            end
            ST_DIRECT: begin
                q_nxt_s   = decode(bus.i);
                idx_nxt_s = bus.i;
            end
            ST_SCAN: begin
                // Entering from any other state restarts the dwell at the held index.
                if (advance_s) begin
                    idx_nxt_s  = idx_inc_s;
                    q_nxt_s    = decode(idx_inc_s);
                    wrap_nxt_s = &idx_r;
                end else if (state_r == ST_SCAN) begin
                    q_nxt_s   = decode(idx_r);
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    q_nxt_s   = decode(idx_r);
                    cnt_nxt_s = '0;
                end
            end
`ifdef DEC_BLANK_EN
            ST_BLANK: begin
                idx_nxt_s  = idx_inc_s;
                wrap_nxt_s = &idx_r;
            end
`endif
            default: begin
                q_nxt_s = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            q_r     <= '0;
            idx_r   <= '0;
            cnt_r   <= '0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign bus.q    = q_r;
    assign bus.idx  = idx_r;
    assign bus.wrap = wrap_r;
endmodule
